// File: rtl/spi_int_pkg.sv
// Shared constants for the SPI slave interrupt controller: default sizes and
// the source index of each SPI core event.
package spi_int_pkg;

    localparam int N_SRC_DEF = 4;
    localparam int CNT_W_DEF = 4;

    localparam int INT_TXE = 0;
    localparam int INT_RXF = 1;
    localparam int INT_OVR = 2;
    localparam int INT_UDR = 3;

endpackage

// File: rtl/spi_int_src.sv
// One interrupt source: rising-edge detect on the raw core event, a sticky
// flag and a saturating count of events that arrived while the flag was pending.
module spi_int_src
    import spi_int_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             src_evt,
    input  logic             int_en,
    input  logic             int_clr,
    output logic             int_fl,
    output logic [CNT_W-1:0] lost_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic src_prev;
    logic evt;

    assign evt = src_evt & ~src_prev & int_en;

    // src_prev tracks the level even while disabled or in reset, so a level
    // already high when the source becomes live never looks like a new edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_prev <= src_evt;
            int_fl   <= 1'b0;
            lost_cnt <= '0;
        end else begin
            src_prev <= src_evt;
            if (!int_en) begin
                int_fl   <= 1'b0;
                lost_cnt <= '0;
            end else if (evt) begin
                int_fl <= 1'b1;
                // A clear in the same cycle acknowledges the old events; the
                // new one is held by the flag, so nothing is lost.
                if (int_clr)
                    lost_cnt <= '0;
                else if (int_fl && lost_cnt != CNT_MAX)
                    lost_cnt <= lost_cnt + CNT_W'(1);
            end else if (int_clr) begin
                int_fl   <= 1'b0;
                lost_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/spi_int_ctrl.sv
// SPI slave interrupt controller: one spi_int_src per source plus the
// registered, mask-gated interrupt request.
module spi_int_ctrl
    import spi_int_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_SRC-1:0]       src_evt,
    input  logic [N_SRC-1:0]       int_en,
    input  logic [N_SRC-1:0]       int_msk,
    input  logic [N_SRC-1:0]       int_clr,
    output logic [N_SRC-1:0]       int_fl,
    output logic [N_SRC*CNT_W-1:0] lost_cnt,
    output logic                   irq
);

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        spi_int_src #(
            .CNT_W (CNT_W)
        ) u_src (
            .clk      (clk),
            .rst      (rst),
            .src_evt  (src_evt[i]),
            .int_en   (int_en[i]),
            .int_clr  (int_clr[i]),
            .int_fl   (int_fl[i]),
            .lost_cnt (lost_cnt[i*CNT_W +: CNT_W])
        );
    end

    // Built from the registered flags, so irq trails a new flag by one cycle.
    always_ff @(posedge clk) begin
        if (rst)
            irq <= 1'b0;
        else
            irq <= |(int_fl & ~int_msk);
    end

endmodule

// File: doc/spi_int_ctrl.md
# spi_int_ctrl

Interrupt controller for the SPI slave peripheral. It sits between the SPI core's event sources and the APB register block: it drives the control side of the interrupt bundle, consuming per-source enable, mask and clear and producing sticky flags. It edge-detects raw core events into sticky per-source flags, counts events lost while a flag is already pending, and drives a single registered interrupt request to the system.

## Interface

- N_SRC, 4: number of interrupt sources.
- CNT_W, 4: width of each per-source lost-event counter; the counter saturates.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- src_evt  in  N_SRC  raw event levels from the SPI core. Bit i is sourced from package index i.
- int_en  in  N_SRC  per-source enable from APB.
- int_msk  in  N_SRC  per-source mask from APB; 1 blocks the source from irq.
- int_clr  in  N_SRC  per-source clear; a one-cycle write-1-to-clear pulse from APB.
- int_fl  out  N_SRC  sticky raw flags, unmasked, for APB readback.
- lost_cnt  out  N_SRC*CNT_W  packed lost-event counters. Source i occupies [i*CNT_W +: CNT_W].
- irq  out  1  registered interrupt request to the system.

## Operation

- Edge detect:
  - Per source, register src_prev.
  - evt_i = src_evt[i] & ~src_prev[i] & int_en[i].
- While rst is high:
  - src_prev loads src_evt. A level held through reset therefore produces no event after release.
  - int_fl, lost_cnt and irq are 0.
- Flag update, per source, in priority order:
  1. If int_en = 0, the flag is forced to 0 and the counter is forced to 0.
  2. Otherwise, if evt_i, the flag is set to 1.
  3. Otherwise, if int_clr, the flag is set to 0.
  4. Otherwise, the flag holds.
- Simultaneous evt_i and int_clr: the set wins, so the flag stays 1. The counter clears to 0, because the new event is not lost.
- Lost-event counter:
  - Increments when evt_i is true while the flag is already 1 and int_clr is 0.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - Clears on int_clr.
  - The counter is read-only. APB has no write path to it.
- Masking:
  - int_msk does not affect int_fl or lost_cnt.
  - A flag set while masked raises irq one cycle after the mask is removed.
- irq is registered: irq <= |(int_fl & ~int_msk). It is evaluated from the current registered flags.
- The block has no further state machine. Each source is a two-state machine (IDLE: flag=0, PEND: flag=1) plus a counter.

## Timing

- src_evt[i] first sampled high at edge k:
  - int_fl[i] = 1 after edge k.
  - irq = 1 after edge k+1.
- int_clr sampled at edge k, with no concurrent event:
  - int_fl = 0 after edge k.
  - irq = 0 after edge k+1, provided no other unmasked flag is set.
- The mask takes effect on irq with a latency of 1 cycle.
- An enable drop at edge k clears the flag and counter after edge k.
- Events need no minimum width. Two rising edges need at least one low cycle between them to count separately.
- Reset mid-operation: every output is 0 after the first edge with rst high, regardless of any pending clr or event.

## Structure

- Package spi_int_pkg holds:
  - N_SRC_DEF = 4 and CNT_W_DEF = 4.
  - Source indices: INT_TXE = 0, INT_RXF = 1, INT_OVR = 2, INT_UDR = 3.
- Sub-module spi_int_src holds one source's edge detect, flag and saturating counter. It is instantiated N_SRC times in a generate loop.
- The top level contains only the generate loop and the irq OR/register.

## Test plan

- Basic set and clear:
  - Stimulus: int_en = 4'b0001, pulse src_evt[0] high for 1 cycle at edge 10, then pulse int_clr[0] at edge 20.
  - Required: int_fl[0] = 1 after edge 10, irq = 1 after edge 11, int_fl[0] = 0 after edge 20, irq = 0 after edge 21.
- Masking:
  - Stimulus: int_en = 4'hF, int_msk = 4'h2, event on source 1.
  - Required: int_fl[1] = 1 and irq stays 0. Clearing int_msk at edge k gives irq = 1 after edge k.
- Lost events and saturation:
  - Stimulus: the flag for source 2 is already set, then 20 separate rising edges arrive on src_evt[2].
  - Required: lost_cnt[11:8] = 15, saturated. int_clr[2] returns both the flag and the counter to 0.
- Set/clear collision:
  - Stimulus: src_evt[3] rising edge and int_clr[3] in the same cycle, with the flag already 1 and lost_cnt[15:12] = 3.
  - Required: the flag stays 1 and the counter becomes 0.
- Disabled source and reset:
  - Stimulus: an event arrives with int_en[0] = 0.
  - Required: the flag stays 0.
  - Stimulus: all flags set, then rst is asserted for 1 cycle.
  - Required: all outputs are 0. src_evt held high across reset gives no flag after release.
